// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle CPU sequencer: steps an instruction through fetch, execute,
// memory and write-back, with stall/retire counters and a bus-stall watchdog.
module cpu_seq_ctrl #(
  parameter bit P_DECODE_BUF   = 1'b0,
  parameter bit P_RF_READ_BUF  = 1'b0,
  parameter bit P_MEM_BUF      = 1'b0,
  parameter bit P_WAIT_FOR_ACK = 1'b0,
  parameter int P_TIMEOUT      = 0,
  parameter int P_TO_W         = 8,
  parameter int P_CNT_W        = 32
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_sleep,
  input  logic               i_exec_done,
  input  logic               i_dmem_wr,
  input  logic               i_dmem_rd,
  input  logic               i_wb,
  input  logic               i_ibus_busy,
  input  logic               i_dbus_busy,
  input  logic               i_dbus_ack,
  input  logic               i_trap_ack,
  output logic               o_en_fetch,
  output logic               o_update_pc,
  output logic               o_en_decode,
  output logic               o_en_rf_rd,
  output logic               o_en_exec,
  output logic               o_en_dmem_wr,
  output logic               o_en_dmem_rd,
  output logic               o_en_wb,
  output logic               o_wb_state,
  output logic               o_retire,
  output logic               o_trap,
  output logic [1:0]         o_trap_cause,
  output logic [P_CNT_W-1:0] o_stall_cnt,
  output logic [P_CNT_W-1:0] o_retire_cnt
);

  typedef enum logic [2:0] {
    ST_INIT       = 3'd0,
    ST_DECODE     = 3'd1,
    ST_READ_RF    = 3'd2,
    ST_EXECUTE    = 3'd3,
    ST_MEM_PREBUF = 3'd4,
    ST_MEMORY     = 3'd5,
    ST_WRITE_BACK = 3'd6,
    ST_TRAP       = 3'd7
  } state_e;

  // First state of every instruction after the fetch has been accepted.
  localparam state_e ST_S = P_DECODE_BUF  ? ST_DECODE  :
                            P_RF_READ_BUF ? ST_READ_RF : ST_EXECUTE;

  localparam int              TO_LIM_I = (P_TIMEOUT > 0) ? P_TIMEOUT - 1 : 0;
  localparam logic [P_TO_W-1:0] TO_LIM = TO_LIM_I[P_TO_W-1:0];

  state_e             state_q, state_d, nat_next;
  logic [P_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [P_CNT_W-1:0] retire_cnt_q, retire_cnt_d;
  logic [P_TO_W-1:0]  wd_q, wd_d;
  logic [1:0]         trap_cause_q, trap_cause_d;
  logic               dready, stall, timeout;

  assign dready = !i_dbus_busy && (!P_WAIT_FOR_ACK || i_dbus_ack);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    nat_next     = state_q;
    o_en_fetch   = 1'b0;
    o_update_pc  = 1'b0;
    o_en_decode  = 1'b0;
    o_en_rf_rd   = 1'b0;
    o_en_exec    = 1'b0;
    o_en_dmem_wr = 1'b0;
    o_en_dmem_rd = 1'b0;
    o_en_wb      = 1'b0;
    o_wb_state   = 1'b0;
    o_trap       = 1'b0;

    case (state_q)
      ST_INIT: begin
        o_en_fetch  = 1'b1;
        o_en_decode = 1'b1;
        o_update_pc = !i_ibus_busy;
        if (!i_ibus_busy) nat_next = ST_S;
      end
      ST_DECODE: begin
        o_en_decode = 1'b1;
        nat_next    = P_RF_READ_BUF ? ST_READ_RF : ST_EXECUTE;
      end
      ST_READ_RF: begin
        o_en_decode = 1'b1;
        o_en_rf_rd  = 1'b1;
        nat_next    = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        o_en_exec    = 1'b1;
        o_en_decode  = 1'b1;
        o_en_dmem_wr = i_dmem_wr;
        o_en_fetch   = i_exec_done && !i_dmem_rd;
        o_update_pc  = i_exec_done && !i_dmem_rd;
        if (i_exec_done) begin
          if (i_dmem_rd || i_dmem_wr) nat_next = P_MEM_BUF ? ST_MEM_PREBUF : ST_MEMORY;
          else                        nat_next = ST_WRITE_BACK;
        end
      end
      ST_MEM_PREBUF: begin
        o_en_dmem_rd = i_dmem_rd;
        nat_next     = ST_MEMORY;
      end
      ST_MEMORY: begin
        o_en_dmem_rd = i_dmem_rd;
        o_en_fetch   = i_dmem_rd && dready;
        o_update_pc  = i_dmem_rd && dready;
        o_en_wb      = i_wb && !i_dmem_rd;
        if (dready) begin
          if (i_dmem_rd)                     nat_next = ST_WRITE_BACK;
          else if (i_dmem_wr && !i_ibus_busy) nat_next = ST_S;
        end
      end
      ST_WRITE_BACK: begin
        o_en_wb      = i_wb;
        o_en_dmem_rd = i_dmem_rd;
        o_wb_state   = 1'b1;
        if (!i_ibus_busy) nat_next = ST_S;
      end
      ST_TRAP: begin
        o_trap = 1'b1;
        if (i_trap_ack) nat_next = ST_INIT;
      end
      default: nat_next = ST_INIT;
    endcase

    // Only bus-facing waits count as stalls; a slow execute unit does not.
    stall = !i_sleep && (nat_next == state_q) &&
            (state_q == ST_INIT || state_q == ST_MEMORY || state_q == ST_WRITE_BACK);
    // A bus that becomes ready clears stall, so forward progress beats the timeout.
    timeout = (P_TIMEOUT > 0) && stall && (wd_q == TO_LIM);

    o_retire = !i_sleep && (nat_next == ST_S) &&
               (state_q == ST_MEMORY || state_q == ST_WRITE_BACK);

    if (i_sleep)      state_d = state_q;
    else if (timeout) state_d = ST_TRAP;
    else              state_d = nat_next;

    stall_cnt_d  = stall    ? stall_cnt_q  + P_CNT_W'(1) : stall_cnt_q;
    retire_cnt_d = o_retire ? retire_cnt_q + P_CNT_W'(1) : retire_cnt_q;

    if (i_sleep)                 wd_d = wd_q;
    else if (state_d != state_q) wd_d = '0;
    else if (stall)              wd_d = wd_q + P_TO_W'(1);
    else                         wd_d = wd_q;

    trap_cause_d = trap_cause_q;
    if (timeout) trap_cause_d = (state_q == ST_MEMORY && !dready) ? 2'b10 : 2'b01;

    if (i_sleep) begin
      o_en_fetch   = 1'b0;
      o_update_pc  = 1'b0;
      o_en_decode  = 1'b0;
      o_en_rf_rd   = 1'b0;
      o_en_exec    = 1'b0;
      o_en_dmem_wr = 1'b0;
      o_en_dmem_rd = 1'b0;
      o_en_wb      = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!i_rst_n) begin
      state_q      <= ST_INIT;
      stall_cnt_q  <= '0;
      retire_cnt_q <= '0;
      wd_q         <= '0;
      trap_cause_q <= 2'b00;
    end else begin
      state_q      <= state_d;
      stall_cnt_q  <= stall_cnt_d;
      retire_cnt_q <= retire_cnt_d;
      wd_q         <= wd_d;
      trap_cause_q <= trap_cause_d;
    end
  end

  assign o_trap_cause = trap_cause_q;
  assign o_stall_cnt  = stall_cnt_q;
  assign o_retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Directed scoreboard bench: a default-parameter instance and a configured
// instance (memory prebuffer, ack wait, timeout 4) share one stimulus stream.
module tb_cpu_seq_ctrl;

  localparam logic [10:0] O_FETCH = 11'b100_0000_0000;
  localparam logic [10:0] O_UPC   = 11'b010_0000_0000;
  localparam logic [10:0] O_DEC   = 11'b001_0000_0000;
  localparam logic [10:0] O_RF    = 11'b000_1000_0000;
  localparam logic [10:0] O_EXEC  = 11'b000_0100_0000;
  localparam logic [10:0] O_DWR   = 11'b000_0010_0000;
  localparam logic [10:0] O_DRD   = 11'b000_0001_0000;
  localparam logic [10:0] O_WB    = 11'b000_0000_1000;
  localparam logic [10:0] O_WBS   = 11'b000_0000_0100;
  localparam logic [10:0] O_RET   = 11'b000_0000_0010;
  localparam logic [10:0] O_TRAP  = 11'b000_0000_0001;
  localparam logic [10:0] O_NONE  = 11'b000_0000_0000;

  logic clk = 1'b0;
  logic rst_n, sleep, exec_done, dmem_wr, dmem_rd, wb;
  logic ibus_busy, dbus_busy, dbus_ack, trap_ack;

  logic        b_fetch, b_upc, b_dec, b_rf, b_exec, b_dwr, b_drd, b_wb, b_wbs, b_ret, b_trap;
  logic [1:0]  b_cause;
  logic [31:0] b_stall, b_retire;
  logic        c_fetch, c_upc, c_dec, c_rf, c_exec, c_dwr, c_drd, c_wb, c_wbs, c_ret, c_trap;
  logic [1:0]  c_cause;
  logic [31:0] c_stall, c_retire;

  always #5 clk = ~clk;

  cpu_seq_ctrl u_base (
    .i_clk(clk), .i_rst_n(rst_n), .i_sleep(sleep), .i_exec_done(exec_done),
    .i_dmem_wr(dmem_wr), .i_dmem_rd(dmem_rd), .i_wb(wb), .i_ibus_busy(ibus_busy),
    .i_dbus_busy(dbus_busy), .i_dbus_ack(dbus_ack), .i_trap_ack(trap_ack),
    .o_en_fetch(b_fetch), .o_update_pc(b_upc), .o_en_decode(b_dec), .o_en_rf_rd(b_rf),
    .o_en_exec(b_exec), .o_en_dmem_wr(b_dwr), .o_en_dmem_rd(b_drd), .o_en_wb(b_wb),
    .o_wb_state(b_wbs), .o_retire(b_ret), .o_trap(b_trap), .o_trap_cause(b_cause),
    .o_stall_cnt(b_stall), .o_retire_cnt(b_retire)
  );

  cpu_seq_ctrl #(
    .P_MEM_BUF(1'b1), .P_WAIT_FOR_ACK(1'b1), .P_TIMEOUT(4)
  ) u_cfg (
    .i_clk(clk), .i_rst_n(rst_n), .i_sleep(sleep), .i_exec_done(exec_done),
    .i_dmem_wr(dmem_wr), .i_dmem_rd(dmem_rd), .i_wb(wb), .i_ibus_busy(ibus_busy),
    .i_dbus_busy(dbus_busy), .i_dbus_ack(dbus_ack), .i_trap_ack(trap_ack),
    .o_en_fetch(c_fetch), .o_update_pc(c_upc), .o_en_decode(c_dec), .o_en_rf_rd(c_rf),
    .o_en_exec(c_exec), .o_en_dmem_wr(c_dwr), .o_en_dmem_rd(c_drd), .o_en_wb(c_wb),
    .o_wb_state(c_wbs), .o_retire(c_ret), .o_trap(c_trap), .o_trap_cause(c_cause),
    .o_stall_cnt(c_stall), .o_retire_cnt(c_retire)
  );

  logic [10:0] b_obs, c_obs;
  assign b_obs = {b_fetch, b_upc, b_dec, b_rf, b_exec, b_dwr, b_drd, b_wb, b_wbs, b_ret, b_trap};
  assign c_obs = {c_fetch, c_upc, c_dec, c_rf, c_exec, c_dwr, c_drd, c_wb, c_wbs, c_ret, c_trap};

  typedef struct {
    string       tag;
    bit          sel;
    logic [10:0] outs;
    logic [1:0]  cause;
    logic [31:0] stall;
    logic [31:0] ret;
  } exp_t;

  exp_t sb_q[$];
  int   test_cnt = 0;
  int   fail_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    test_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Push the expectation for the current input cycle, then compare mid-cycle.
  task automatic cyc(input string tag, input bit sel, input logic [10:0] outs,
                     input logic [1:0] cause, input logic [31:0] st, input logic [31:0] rt);
    exp_t e;
    e.tag = tag; e.sel = sel; e.outs = outs; e.cause = cause; e.stall = st; e.ret = rt;
    sb_q.push_back(e);
    @(negedge clk);
    e = sb_q.pop_front();
    check({e.tag, "/outs"},   32'(e.sel ? c_obs    : b_obs),    32'(e.outs));
    check({e.tag, "/cause"},  32'(e.sel ? c_cause  : b_cause),  32'(e.cause));
    check({e.tag, "/stall"},  e.sel ? c_stall  : b_stall,  e.stall);
    check({e.tag, "/retire"}, e.sel ? c_retire : b_retire, e.ret);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; sleep = 1'b0; exec_done = 1'b0; dmem_wr = 1'b0; dmem_rd = 1'b0;
    wb = 1'b0; ibus_busy = 1'b0; dbus_busy = 1'b0; dbus_ack = 1'b0; trap_ack = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // ALU op on the default instance, with a busy instruction bus after reset.
    do_reset();
    ibus_busy = 1'b1;
    cyc("s1_init_busy", 0, O_FETCH | O_DEC, 2'b00, 0, 0);
    ibus_busy = 1'b0;
    cyc("s1_init", 0, O_FETCH | O_UPC | O_DEC, 2'b00, 1, 0);
    exec_done = 1'b1; wb = 1'b1;
    cyc("s1_exec", 0, O_EXEC | O_DEC | O_FETCH | O_UPC, 2'b00, 1, 0);
    exec_done = 1'b0;
    cyc("s1_wb", 0, O_WB | O_WBS | O_RET, 2'b00, 1, 0);
    cyc("s1_exec_wait", 0, O_EXEC | O_DEC, 2'b00, 1, 1);
    cyc("s1_exec_wait2", 0, O_EXEC | O_DEC, 2'b00, 1, 1);

    // Load with a prebuffer and an ack arriving after three stall cycles.
    do_reset();
    cyc("s2_init", 1, O_FETCH | O_UPC | O_DEC, 2'b00, 0, 0);
    exec_done = 1'b1; dmem_rd = 1'b1; wb = 1'b1;
    cyc("s2_exec", 1, O_EXEC | O_DEC, 2'b00, 0, 0);
    exec_done = 1'b0;
    cyc("s2_prebuf", 1, O_DRD, 2'b00, 0, 0);
    for (int i = 0; i < 3; i++) cyc("s2_mem_wait", 1, O_DRD, 2'b00, 32'(i), 0);
    dbus_ack = 1'b1;
    cyc("s2_mem_ack", 1, O_DRD | O_FETCH | O_UPC, 2'b00, 3, 0);
    dbus_ack = 1'b0;
    cyc("s2_wb", 1, O_WB | O_DRD | O_WBS | O_RET, 2'b00, 3, 0);
    dmem_rd = 1'b0; wb = 1'b0;
    cyc("s2_exec_next", 1, O_EXEC | O_DEC, 2'b00, 3, 1);

    // Store with the data bus stuck busy: watchdog trap after four stalls.
    do_reset();
    cyc("s3_init", 1, O_FETCH | O_UPC | O_DEC, 2'b00, 0, 0);
    exec_done = 1'b1; dmem_wr = 1'b1;
    cyc("s3_exec", 1, O_EXEC | O_DEC | O_DWR | O_FETCH | O_UPC, 2'b00, 0, 0);
    exec_done = 1'b0; dbus_busy = 1'b1;
    cyc("s3_prebuf", 1, O_NONE, 2'b00, 0, 0);
    for (int i = 0; i < 4; i++) cyc("s3_mem_stall", 1, O_NONE, 2'b00, 32'(i), 0);
    cyc("s3_trap", 1, O_TRAP, 2'b10, 4, 0);
    cyc("s3_trap_hold", 1, O_TRAP, 2'b10, 4, 0);
    trap_ack = 1'b1;
    cyc("s3_trap_ack", 1, O_TRAP, 2'b10, 4, 0);
    trap_ack = 1'b0; dbus_busy = 1'b0; dmem_wr = 1'b0;
    cyc("s3_init_after", 1, O_FETCH | O_UPC | O_DEC, 2'b10, 4, 0);

    // Store whose bus becomes ready on the cycle the timeout would fire.
    do_reset();
    cyc("s4_init", 1, O_FETCH | O_UPC | O_DEC, 2'b00, 0, 0);
    exec_done = 1'b1; dmem_wr = 1'b1;
    cyc("s4_exec", 1, O_EXEC | O_DEC | O_DWR | O_FETCH | O_UPC, 2'b00, 0, 0);
    exec_done = 1'b0; dbus_busy = 1'b1;
    cyc("s4_prebuf", 1, O_NONE, 2'b00, 0, 0);
    for (int i = 0; i < 3; i++) cyc("s4_mem_stall", 1, O_NONE, 2'b00, 32'(i), 0);
    dbus_busy = 1'b0; dbus_ack = 1'b1;
    cyc("s4_mem_ready", 1, O_RET, 2'b00, 3, 0);
    dbus_ack = 1'b0; dmem_wr = 1'b0;
    cyc("s4_exec_next", 1, O_EXEC | O_DEC, 2'b00, 3, 1);

    // Load frozen by sleep mid-memory, then reset while still waiting.
    exec_done = 1'b1; dmem_rd = 1'b1; wb = 1'b1;
    cyc("s5_exec", 1, O_EXEC | O_DEC, 2'b00, 3, 1);
    exec_done = 1'b0;
    cyc("s5_prebuf", 1, O_DRD, 2'b00, 3, 1);
    cyc("s5_mem", 1, O_DRD, 2'b00, 3, 1);
    sleep = 1'b1; dbus_ack = 1'b1;
    for (int i = 0; i < 5; i++) cyc("s5_sleep", 1, O_NONE, 2'b00, 4, 1);
    sleep = 1'b0; dbus_ack = 1'b0;
    cyc("s5_mem_post", 1, O_DRD, 2'b00, 4, 1);
    cyc("s5_mem_post2", 1, O_DRD, 2'b00, 5, 1);
    sleep = 1'b1; rst_n = 1'b0;
    @(posedge clk);
    #1;
    sleep = 1'b0; rst_n = 1'b1;
    cyc("s5_after_rst", 1, O_FETCH | O_UPC | O_DEC, 2'b00, 0, 0);

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/cpu_seq_ctrl.md
CPU_SEQ_CTRL -- requirements
Module: cpu_seq_ctrl

Interface
REQ-001 SHALL have parameter P_DECODE_BUF, default 0: add the ST_DECODE state before register read / execute.
REQ-002 SHALL have parameter P_RF_READ_BUF, default 0: add the ST_READ_RF state for a synchronous register-file read.
REQ-003 SHALL have parameter P_MEM_BUF, default 0: add the ST_MEM_PREBUF state before ST_MEMORY.
REQ-004 SHALL have parameter P_WAIT_FOR_ACK, default 0: the data bus is ready only when i_dbus_ack is also high.
REQ-005 SHALL have parameter P_TIMEOUT, default 0: bus-stall watchdog limit in cycles; 0 disables the watchdog; legal range 0..2^P_TO_W-1.
REQ-006 SHALL have parameter P_TO_W, default 8: watchdog counter width.
REQ-007 SHALL have parameter P_CNT_W, default 32: width of the performance counters.
REQ-008 SHALL have ports: i_clk in 1 (clock); i_rst_n in 1 (reset; one clock, reset synchronous and active-low).
REQ-009 SHALL have inputs, 1 bit each:
- i_sleep: freeze.
- i_exec_done: execute finished.
- i_dmem_wr, i_dmem_rd: store / load.
- i_wb: instruction writes rd.
- i_ibus_busy, i_dbus_busy, i_dbus_ack: bus status.
- i_trap_ack: trap handled.
REQ-010 SHALL have 1-bit outputs: o_en_fetch, o_update_pc, o_en_decode, o_en_rf_rd, o_en_exec, o_en_dmem_wr, o_en_dmem_rd, o_en_wb, o_wb_state, o_retire, o_trap.
REQ-011 SHALL have outputs o_trap_cause (2 bits: 01 = ibus timeout, 10 = dbus timeout), o_stall_cnt (P_CNT_W bits) and o_retire_cnt (P_CNT_W bits).

Function
REQ-012 SHALL define the following terms.
- dready = !i_dbus_busy && (!P_WAIT_FOR_ACK || i_dbus_ack).
- S = ST_DECODE if P_DECODE_BUF; otherwise ST_READ_RF if P_RF_READ_BUF; otherwise ST_EXECUTE.
REQ-013 SHALL implement the states ST_INIT, ST_DECODE, ST_READ_RF, ST_EXECUTE, ST_MEM_PREBUF, ST_MEMORY, ST_WRITE_BACK and ST_TRAP; unreachable encodings SHALL go to ST_INIT.
REQ-014 SHALL make these transitions: ST_INIT -> S when !i_ibus_busy; ST_DECODE -> ST_READ_RF if P_RF_READ_BUF, else ST_EXECUTE; ST_READ_RF -> ST_EXECUTE.
REQ-015 SHALL, in ST_EXECUTE, stay until i_exec_done, then go to (ST_MEM_PREBUF if P_MEM_BUF, else ST_MEMORY) when i_dmem_rd||i_dmem_wr, else to ST_WRITE_BACK; ST_MEM_PREBUF -> ST_MEMORY.
REQ-016 SHALL, in ST_MEMORY, stay while !dready; on dready with i_dmem_rd go to ST_WRITE_BACK; on dready with a store and !i_ibus_busy go to S; otherwise stay.
REQ-017 SHALL, in ST_WRITE_BACK, go to S when !i_ibus_busy, else stay; ST_TRAP stays until i_trap_ack, then goes to ST_INIT.
REQ-018 SHALL drive outputs per state; outputs not listed for a state are 0.
- INIT: o_en_fetch=1, o_en_decode=1, o_update_pc=!i_ibus_busy.
- DECODE: o_en_decode=1.
- READ_RF: o_en_decode=1, o_en_rf_rd=1.
- EXECUTE: o_en_exec=1, o_en_decode=1, o_en_dmem_wr=i_dmem_wr, o_en_fetch=o_update_pc=i_exec_done&&!i_dmem_rd.
- MEM_PREBUF: o_en_dmem_rd=i_dmem_rd.
- MEMORY: o_en_dmem_rd=i_dmem_rd, o_en_fetch=o_update_pc=i_dmem_rd&&dready, o_en_wb=i_wb&&!i_dmem_rd.
- WRITE_BACK: o_en_wb=i_wb, o_en_dmem_rd=i_dmem_rd, o_wb_state=1.
- TRAP: o_trap=1.
REQ-019 SHALL pulse o_retire for exactly one cycle, combinationally, on every transition from ST_MEMORY or ST_WRITE_BACK to S.
REQ-020 SHALL increment o_retire_cnt on each o_retire cycle, with modulo 2^P_CNT_W wrap.
REQ-021 SHALL count stall cycles in o_stall_cnt.
- A stall cycle is any non-sleep cycle in ST_INIT, ST_MEMORY or ST_WRITE_BACK where the state is held.
- The count wraps modulo 2^P_CNT_W.
- Waiting in ST_EXECUTE is not a stall.
REQ-022 SHALL implement the watchdog with a P_TO_W-bit counter.
- The counter increments on each stall cycle.
- The counter clears on any state change.
- When P_TIMEOUT>0 and the counter equals P_TIMEOUT-1 on a stall cycle, the next state is ST_TRAP.
REQ-023 SHALL register o_trap_cause on entry to ST_TRAP (10 if entered from ST_MEMORY with !dready, else 01) and hold it until the next trap entry or reset.
REQ-024 SHALL let forward progress win if a bus becomes ready in the same cycle the timeout is reached: no trap is taken.
REQ-025 SHALL, while i_sleep=1, hold the state, both counters and the watchdog, and force every 1-bit output except o_trap and o_wb_state to 0.

Reset
REQ-026 SHALL, on a cycle with i_rst_n=0 sampled at posedge i_clk, set the state to ST_INIT and clear o_stall_cnt, o_retire_cnt, the watchdog and o_trap_cause; this takes priority over sleep and applies mid-operation.
REQ-027 SHALL, in the first cycle after reset, drive o_en_fetch=1, o_en_decode=1, o_trap=0, o_retire=0, and o_update_pc=!i_ibus_busy.

Verification
REQ-028 SHALL cover: all P_*_BUF=0, ALU op with i_wb=1, i_exec_done asserted in the first execute cycle -> INIT, EXECUTE, WRITE_BACK, EXECUTE; o_retire in the 3rd cycle; o_retire_cnt=1.
REQ-029 SHALL cover: P_MEM_BUF=1, P_WAIT_FOR_ACK=1, load with i_dbus_ack delayed 3 cycles -> PREBUF, then MEMORY held 3 cycles, then WRITE_BACK; o_stall_cnt=3; o_en_fetch high only in the ack cycle.
REQ-030 SHALL cover: P_TIMEOUT=4, i_dbus_busy stuck during a store -> ST_TRAP after 4 MEMORY stall cycles, o_trap_cause=10; i_trap_ack -> ST_INIT next cycle.
REQ-031 SHALL cover: P_TIMEOUT=4, dready rising on the 4th stall cycle -> no trap; normal retire.
REQ-032 SHALL cover: i_sleep=1 for 5 cycles mid ST_MEMORY -> state and counters unchanged, enables 0; then i_rst_n=0 mid-load -> ST_INIT, counters 0.
